// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small byte FIFO
//
// Purpose:
//   Debug UART transmit path. Upstream logic pushes bytes with a write strobe;
//   the FIFO buffers them and an 8N1 serializer drains them onto the TX pin,
//   back-to-back with no idle gap while data is queued.
//
// Parameters:
//   CLK_HZ      input clock frequency in Hz
//   BAUD        serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (truncated, >= 2)
//   FIFO_DEPTH  byte entries, power of two, >= 2
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   wr_data   byte to enqueue
//   wr_en     enqueue strobe, one byte per cycle while high
//   full      FIFO holds FIFO_DEPTH bytes (registered)
//   empty     FIFO holds 0 bytes (registered)
//   overflow  sticky, a write was attempted while full; cleared by rst only
//   busy      serializer is in START/DATA/STOP
//   tx        serial line, idle high, driven from a flop

module uart_tx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [7:0]    head;

  logic          do_write;
  logic          do_pop;

  // Serializer state (declared here because the pop decision depends on it)
  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_wrap;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign head      = mem[rd_ptr];
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // full is the registered pre-edge flag, so a write on the same edge as a
  // pop is still dropped when the FIFO was full going into that edge.
  assign do_write = wr_en && !full;

  // The serializer is the only consumer: it pops from IDLE as soon as data is
  // present, or on the last STOP cycle to chain the next frame with no gap.
  assign do_pop = !empty &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && baud_wrap));

  always_comb begin
    count_next = count;
    case ({do_write, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Data array carries no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      count <= count_next;
      // Flags follow the post-edge count so they are valid one flop later.
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // 8N1 serializer
  // tx is registered and always updated on the same edge as the state change,
  // so each line level lasts exactly CLKS_PER_BIT cycles and a frame is
  // exactly 10*CLKS_PER_BIT cycles long.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (do_pop) begin
            shift <= head;
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        ST_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              // Next bit is shift[1] before the shift lands.
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        ST_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (do_pop) begin
              // Chain straight into the next start bit.
              shift <= head;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       busy;
  logic       tx;

  int n_tests;
  int n_fail;

  // busy monitor, sampled on the falling edge
  int   busy_cycles;
  int   busy_rises;
  logic busy_d;

  uart_tx_fifo #(
    .CLK_HZ    (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .busy    (busy),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles = busy_cycles + 1;
    if (busy === 1'b1 && busy_d !== 1'b1) busy_rises = busy_rises + 1;
    busy_d = busy;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic clear_mon();
    busy_cycles = 0;
    busy_rises  = 0;
  endtask

  // Entered at frame cycle 'phase' (cycle 0 = first cycle tx is low).
  // Samples mid-bit, returns at cycle 100 of the frame. Optionally drives a
  // write onto the edge that ends the STOP bit.
  task automatic get_frame(input string tag, input int phase, input logic [7:0] exp,
                           input bit do_wr, input logic [7:0] wdat);
    logic [7:0] d;
    logic       sb;
    logic       pb;
    d = 8'h00;
    repeat (5 - phase) tick();
    sb = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (10) tick();
      d[i] = tx;
    end
    repeat (10) tick();
    pb = tx;
    repeat (4) tick();
    if (do_wr) begin
      wr_data = wdat;
      wr_en   = 1'b1;
    end
    tick();
    wr_en = 1'b0;
    chk_bit({tag, "_start"}, sb, 1'b0);
    chk_byte({tag, "_data"}, d, exp);
    chk_bit({tag, "_stop"}, pb, 1'b1);
  endtask

  initial begin
    int bad;
    n_tests = 0;
    n_fail  = 0;
    busy_d  = 1'b0;
    clear_mon();
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // reset state
    repeat (3) tick();
    chk_bit("rst_tx", tx, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_empty", empty, 1'b1);
    chk_bit("rst_full", full, 1'b0);
    chk_bit("rst_overflow", overflow, 1'b0);
    rst = 1'b0;

    // idle 100 cycles
    bad = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0)
        bad++;
    end
    chk_int("idle_bad_cycles", bad, 0);

    // single 'H'
    clear_mon();
    write_byte(8'h48);
    chk_bit("h_tx_before_pop", tx, 1'b1);
    chk_bit("h_empty_after_write", empty, 1'b0);
    tick();
    chk_bit("h_tx_low_after_pop", tx, 1'b0);
    chk_bit("h_busy_after_pop", busy, 1'b1);
    chk_bit("h_empty_after_pop", empty, 1'b1);
    get_frame("h", 0, 8'h48, 1'b0, 8'h00);
    chk_bit("h_busy_end", busy, 1'b0);
    chk_int("h_busy_cycles", busy_cycles, 100);

    // "Hello" back-to-back
    clear_mon();
    write_byte(8'h48);
    write_byte(8'h65);
    write_byte(8'h6C);
    write_byte(8'h6C);
    write_byte(8'h6F);
    chk_bit("hello_full", full, 1'b1);
    chk_bit("hello_no_overflow", overflow, 1'b0);
    get_frame("hello0", 3, 8'h48, 1'b0, 8'h00);
    get_frame("hello1", 0, 8'h65, 1'b0, 8'h00);
    get_frame("hello2", 0, 8'h6C, 1'b0, 8'h00);
    get_frame("hello3", 0, 8'h6C, 1'b0, 8'h00);
    get_frame("hello4", 0, 8'h6F, 1'b0, 8'h00);
    chk_bit("hello_empty_end", empty, 1'b1);
    chk_bit("hello_busy_end", busy, 1'b0);
    chk_int("hello_busy_cycles", busy_cycles, 500);
    chk_int("hello_busy_rises", busy_rises, 1);

    // six writes: the sixth is dropped
    repeat (10) tick();
    clear_mon();
    for (int i = 0; i < 6; i++) write_byte(8'h31 + 8'(i));
    chk_bit("ovf_set", overflow, 1'b1);
    chk_bit("ovf_full", full, 1'b1);
    get_frame("ovf0", 4, 8'h31, 1'b0, 8'h00);
    get_frame("ovf1", 0, 8'h32, 1'b0, 8'h00);
    get_frame("ovf2", 0, 8'h33, 1'b0, 8'h00);
    get_frame("ovf3", 0, 8'h34, 1'b0, 8'h00);
    get_frame("ovf4", 0, 8'h35, 1'b0, 8'h00);
    repeat (30) tick();
    chk_int("ovf_busy_cycles", busy_cycles, 500);
    chk_int("ovf_busy_rises", busy_rises, 1);
    chk_bit("ovf_sticky", overflow, 1'b1);
    chk_bit("ovf_empty_end", empty, 1'b1);

    // asynchronous reset in mid DATA
    write_byte(8'h5A);
    write_byte(8'h77);
    repeat (35) tick();
    chk_bit("mid_tx_bit2", tx, 1'b0);
    chk_bit("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("arst_tx", tx, 1'b1);
    chk_bit("arst_busy", busy, 1'b0);
    chk_bit("arst_empty", empty, 1'b1);
    chk_bit("arst_overflow", overflow, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    chk_int("post_rst_idle_bad", bad, 0);
    clear_mon();
    write_byte(8'hC3);
    tick();
    chk_bit("post_rst_tx_low", tx, 1'b0);
    get_frame("post_rst", 0, 8'hC3, 1'b0, 8'h00);
    chk_int("post_rst_busy_cycles", busy_cycles, 100);

    // write on the STOP-end pop edge with count 3
    repeat (10) tick();
    clear_mon();
    write_byte(8'h81);
    write_byte(8'h42);
    write_byte(8'h24);
    write_byte(8'h18);
    get_frame("se0", 2, 8'h81, 1'b1, 8'hF0);
    chk_bit("se_not_full", full, 1'b0);
    chk_bit("se_not_empty", empty, 1'b0);
    chk_bit("se_no_overflow", overflow, 1'b0);
    // count is 3 here, so one more write must make it exactly full
    write_byte(8'h0F);
    chk_bit("se_full_after_one", full, 1'b1);
    chk_bit("se_no_overflow2", overflow, 1'b0);
    get_frame("se1", 1, 8'h42, 1'b0, 8'h00);
    get_frame("se2", 0, 8'h24, 1'b0, 8'h00);
    get_frame("se3", 0, 8'h18, 1'b0, 8'h00);
    get_frame("se4", 0, 8'hF0, 1'b0, 8'h00);
    get_frame("se5", 0, 8'h0F, 1'b0, 8'h00);
    chk_bit("se_empty_end", empty, 1'b1);
    chk_int("se_busy_cycles", busy_cycles, 600);
    chk_int("se_busy_rises", busy_rises, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Debug UART transmit path for the debug_uart project: 8N1 serializer fed by a small byte FIFO.
- Upstream message logic (the hello-world sequencer) pushes ASCII bytes with a write strobe; the block drives the board TX pin.
- LED status logic may sample busy/empty; the block does not drive LEDs.

Parameters:
CLK_HZ, 24000000, input clock frequency in Hz (24 MHz board oscillator).
BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer truncation (208 at defaults); must be >= 2.
FIFO_DEPTH, 16, byte entries; power of two, >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
wr_data  input  8  byte to enqueue.
wr_en  input  1  enqueue strobe, one byte per cycle while high.
full  output  1  FIFO holds FIFO_DEPTH bytes.
empty  output  1  FIFO holds 0 bytes.
overflow  output  1  sticky: a write was attempted while full.
busy  output  1  serializer is mid-frame (START/DATA/STOP).
tx  output  1  serial line, idle high.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, asynchronous and also mid-frame: tx=1, busy=0, empty=1, full=0, overflow=0, FIFO pointers/count cleared, FSM=IDLE, bit counter and baud counter cleared. Any frame in progress is aborted; tx goes high immediately.
- FIFO write: on an edge with wr_en=1 and full=0, store wr_data; count+1.
- FIFO write when full: data dropped and overflow set. This applies even if a pop occurs on the same edge, because full is evaluated pre-edge. overflow clears only on rst.
- FIFO pop: performed only by the FSM. A simultaneous write and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- full/empty: registered, derived from the post-edge count.
- FSM states:
  - IDLE: tx=1, busy=0. If empty=0, pop the head byte into the shift register, go to START, clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final STOP cycle, if empty=0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- busy=1 in START, DATA and STOP.
- Latency: a byte written at edge E0 into an empty FIFO, with the FSM in IDLE, is popped at edge E1. tx falls after E1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- tx is driven from a register (glitch-free); no combinational path from wr_en to tx.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps; the bit boundary occurs on the wrap.

Test Plan:
(CLK_HZ=1000000, BAUD=100000, i.e. CLKS_PER_BIT=10, FIFO_DEPTH=4)
- Reset then idle 100 cycles -> tx=1, busy=0, empty=1, full=0, overflow=0 throughout.
- Write 0x48 ('H') once -> tx low 1 cycle after pop. Bits sampled mid-bit (every 10 clocks) = 0, 0,0,0,1,0,0,1,0, 1. busy high exactly 100 cycles. empty=1 after pop.
- Write "Hello" (0x48 0x65 0x6C 0x6C 0x6F) on consecutive cycles:
  - The first is popped immediately; the other four fill the FIFO, full=1, no overflow.
  - The 5 frames are decoded correctly and back-to-back (500 contiguous busy cycles).
  - empty=1 afterwards.
- Write 6 bytes on consecutive cycles -> the 6th is dropped, overflow=1 and stays 1. Exactly 5 frames transmitted.
- Assert rst at cycle 35 of a frame (mid DATA) -> tx=1 asynchronously, busy=0, FIFO empty. A new write after release produces a clean full frame.
- Write while the FIFO is at count 3 on the same edge as the STOP-end pop -> count stays 3, no overflow, byte order preserved.
